// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: steps the microinstruction counter and
// decodes opcode/flags into the 16-bit control word that gates the datapath.
module microcode_sequencer #(
  parameter int NSTEPS    = 5,
  parameter bit EARLY_END = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  instruction_data,
  input  logic        ovf,
  input  logic        zf,
  input  logic        single_step,
  input  logic        step_req,
  output logic [15:0] ctrl_state,
  output logic [2:0]  step,
  output logic        halted,
  output logic        fetch
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } mode_e;

  localparam logic [2:0] LAST_STEP = 3'(NSTEPS - 1);

  mode_e      mode_q, mode_d;
  logic [2:0] step_q, step_d;
  logic       stepReq_q;
  logic [3:0] opcode;
  logic [15:0] rawCtrl;
  logic       adv;
  logic       laterIdle;
  logic       unusedOperand;

  // Microprogram ROM: fetch in T0/T1 is shared, opcode-specific words from T2 on.
  function automatic logic [15:0] rawWord(input logic [2:0] s, input logic [3:0] op,
                                          input logic c, input logic z);
    logic [15:0] w;
    w = 16'h0000;
    case (s)
      3'd0: w = 16'h4004;
      3'd1: w = 16'h1408;
      3'd2: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: w = 16'h4800;
          4'h5:                   w = 16'h0A00;
          4'h6:                   w = 16'h0802;
          4'h7:                   w = c ? 16'h0802 : 16'h0000;
          4'h8:                   w = z ? 16'h0802 : 16'h0000;
          4'hE:                   w = 16'h0110;
          4'hF:                   w = 16'h8000;
          default:                w = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          4'h1:       w = 16'h1200;
          4'h2, 4'h3: w = 16'h1020;
          4'h4:       w = 16'h2100;
          default:    w = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          4'h2:    w = 16'h0281;
          4'h3:    w = 16'h02C1;
          default: w = 16'h0000;
        endcase
      end
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign opcode        = instruction_data[7:4];
  assign unusedOperand = ^instruction_data[3:0];
  assign rawCtrl       = rawWord(step_q, opcode, ovf, zf);
  assign adv           = (mode_q == RUN) && (!single_step || (step_req && !stepReq_q));

  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q    <= RUN;
      step_q    <= 3'd0;
      stepReq_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      stepReq_q <= step_req;
    end
  end

  // True when every remaining step of the current opcode is idle.
  always_comb begin
    laterIdle = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s > int'(step_q) && s < NSTEPS && rawWord(3'(s), opcode, ovf, zf) != 16'h0000)
        laterIdle = 1'b0;
    end
  end

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (adv) begin
      if (rawCtrl[15])
        mode_d = HALT;
      else if (step_q == LAST_STEP || (EARLY_END && laterIdle))
        step_d = 3'd0;
      else
        step_d = step_q + 3'd1;
    end
  end

  // Enables are only asserted on advancing cycles so a stalled cycle has no side effects.
  always_comb begin
    if (mode_q == HALT)
      ctrl_state = 16'h8000;
    else if (adv)
      ctrl_state = rawCtrl;
    else
      ctrl_state = 16'h0000;
    step   = step_q;
    halted = (mode_q == HALT);
    fetch  = (step_q < 3'd2);
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: directed scenarios plus randomized run
// against a table-driven microprogram model, on a normal and an early-end instance.
module tb_microcode_sequencer;

  localparam int NS0 = 5;
  localparam int NS1 = 6;

  logic        clk = 1'b0;
  logic        clr, ovf, zf, singleStep, stepReq;
  logic [7:0]  instr;
  logic [15:0] ctrl0, ctrl1;
  logic [2:0]  step0, step1;
  logic        halted0, halted1, fetch0, fetch1;

  int checks = 0;
  int errors = 0;

  int          mStep[2];
  bit          mHalted[2];
  bit          mReqPrev;
  logic [15:0] opTable[16][3];
  int          nsOf[2]    = '{NS0, NS1};
  bit          earlyOf[2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  microcode_sequencer #(.NSTEPS(NS0), .EARLY_END(1'b0)) dut0 (
    .clk(clk), .clr(clr), .instruction_data(instr), .ovf(ovf), .zf(zf),
    .single_step(singleStep), .step_req(stepReq),
    .ctrl_state(ctrl0), .step(step0), .halted(halted0), .fetch(fetch0)
  );

  microcode_sequencer #(.NSTEPS(NS1), .EARLY_END(1'b1)) dut1 (
    .clk(clk), .clr(clr), .instruction_data(instr), .ovf(ovf), .zf(zf),
    .single_step(singleStep), .step_req(stepReq),
    .ctrl_state(ctrl1), .step(step1), .halted(halted1), .fetch(fetch1)
  );

  // Reference microprogram: shared fetch, then per-opcode T2..T4 words from a table.
  function automatic logic [15:0] refWord(input int idx, input logic [3:0] op,
                                          input logic c, input logic z);
    if (idx == 0) return 16'h4004;
    if (idx == 1) return 16'h1408;
    if (idx > 4) return 16'h0000;
    if (idx == 2 && op == 4'h7) return c ? 16'h0802 : 16'h0000;
    if (idx == 2 && op == 4'h8) return z ? 16'h0802 : 16'h0000;
    return opTable[op][idx-2];
  endfunction

  function automatic bit refAdv(input int k);
    return !mHalted[k] && (!singleStep || (stepReq && !mReqPrev));
  endfunction

  function automatic logic [15:0] refCtrl(input int k);
    if (mHalted[k]) return 16'h8000;
    if (refAdv(k)) return refWord(mStep[k], instr[7:4], ovf, zf);
    return 16'h0000;
  endfunction

  // Advances the model with the inputs the DUT sees at the coming edge, then waits for it.
  task automatic clockEdge();
    bit advNow[2];
    for (int k = 0; k < 2; k++) advNow[k] = refAdv(k);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        mStep[k]   = 0;
        mHalted[k] = 1'b0;
      end else if (advNow[k]) begin
        if (refWord(mStep[k], instr[7:4], ovf, zf) == 16'h8000) begin
          mHalted[k] = 1'b1;
        end else begin
          int len = nsOf[k];
          if (earlyOf[k]) begin
            len = mStep[k] + 1;
            for (int j = mStep[k] + 1; j < nsOf[k]; j++)
              if (refWord(j, instr[7:4], ovf, zf) != 16'h0000) len = j + 1;
          end
          mStep[k] = (mStep[k] + 1 >= len) ? 0 : mStep[k] + 1;
        end
      end
    end
    mReqPrev = clr ? 1'b0 : stepReq;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; instr = 8'h00; singleStep = 1'b0; stepReq = 1'b0; ovf = 1'b0; zf = 1'b0;
    clockEdge();
    clr = 1'b0;
    #1;
    checks++; if (step0 !== 3'd0) begin errors++; $display("[TB] FAIL reset_step got %0d want 0", step0); end
    checks++; if (ctrl0 !== 16'h4004) begin errors++; $display("[TB] FAIL reset_ctrl got %h want 4004", ctrl0); end
    checks++; if (halted0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b want 0", halted0); end
    checks++; if (fetch0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_fetch got %b want 1", fetch0); end
    checks++; if (ctrl1 !== 16'h4004) begin errors++; $display("[TB] FAIL reset_ctrl_early got %h want 4004", ctrl1); end
    clockEdge();
  endtask

  task automatic test_lda_sequence();
    logic [15:0] expCtrl[6] = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000, 16'h4004};
    int          expStep[6] = '{0, 1, 2, 3, 4, 0};
    clr = 1'b1; clockEdge(); clr = 1'b0;
    instr = 8'h1E;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (ctrl0 !== expCtrl[i]) begin errors++; $display("[TB] FAIL lda_ctrl[%0d] got %h want %h", i, ctrl0, expCtrl[i]); end
      checks++; if (int'(step0) != expStep[i]) begin errors++; $display("[TB] FAIL lda_step[%0d] got %0d want %0d", i, step0, expStep[i]); end
      clockEdge();
    end
  endtask

  task automatic test_alu_jumps();
    logic [7:0] ins[8]  = '{8'h3F, 8'h2A, 8'h70, 8'h71, 8'h80, 8'h85, 8'h4C, 8'hE2};
    logic       ovs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       zfs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 8; c++) begin
      clr = 1'b1; clockEdge(); clr = 1'b0;
      instr = ins[c]; ovf = ovs[c]; zf = zfs[c];
      for (int t = 0; t < 5; t++) begin
        #1;
        checks++; if (ctrl0 !== refCtrl(0)) begin errors++; $display("[TB] FAIL op_ctrl[%h T%0d] got %h want %h", ins[c], t, ctrl0, refCtrl(0)); end
        checks++; if (int'(step0) != mStep[0]) begin errors++; $display("[TB] FAIL op_step[%h T%0d] got %0d want %0d", ins[c], t, step0, mStep[0]); end
        checks++; if (ctrl1 !== refCtrl(1)) begin errors++; $display("[TB] FAIL op_ctrl_early[%h T%0d] got %h want %h", ins[c], t, ctrl1, refCtrl(1)); end
        clockEdge();
      end
    end
    ovf = 1'b0; zf = 1'b0;
  endtask

  task automatic test_halt();
    clr = 1'b1; clockEdge(); clr = 1'b0;
    instr = 8'hF0;
    clockEdge(); clockEdge();
    #1;
    checks++; if (ctrl0 !== 16'h8000) begin errors++; $display("[TB] FAIL halt_t2_ctrl got %h want 8000", ctrl0); end
    clockEdge();
    for (int i = 0; i < 10; i++) begin
      stepReq = 1'($urandom_range(0, 1));
      singleStep = 1'($urandom_range(0, 1));
      #1;
      checks++; if (halted0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag[%0d] got %b want 1", i, halted0); end
      checks++; if (step0 !== 3'd2) begin errors++; $display("[TB] FAIL halt_step[%0d] got %0d want 2", i, step0); end
      checks++; if (ctrl0 !== 16'h8000) begin errors++; $display("[TB] FAIL halt_ctrl[%0d] got %h want 8000", i, ctrl0); end
      clockEdge();
    end
    singleStep = 1'b0; stepReq = 1'b0;
    clr = 1'b1; clockEdge(); clr = 1'b0;
    #1;
    checks++; if (ctrl0 !== 16'h4004) begin errors++; $display("[TB] FAIL halt_clr_ctrl got %h want 4004", ctrl0); end
    checks++; if (halted0 !== 1'b0) begin errors++; $display("[TB] FAIL halt_clr_flag got %b want 0", halted0); end
  endtask

  task automatic test_single_step();
    clr = 1'b1; singleStep = 1'b1; stepReq = 1'b0; instr = 8'h1E;
    clockEdge(); clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctrl0 !== 16'h0000) begin errors++; $display("[TB] FAIL ss_idle_ctrl[%0d] got %h want 0000", i, ctrl0); end
      checks++; if (step0 !== 3'd0) begin errors++; $display("[TB] FAIL ss_idle_step[%0d] got %0d want 0", i, step0); end
      clockEdge();
    end
    stepReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ctrl0 !== ((i == 0) ? 16'h4004 : 16'h0000)) begin errors++; $display("[TB] FAIL ss_hold_ctrl[%0d] got %h", i, ctrl0); end
      checks++; if (step0 !== ((i == 0) ? 3'd0 : 3'd1)) begin errors++; $display("[TB] FAIL ss_hold_step[%0d] got %0d", i, step0); end
      clockEdge();
    end
    stepReq = 1'b0; clockEdge();
    stepReq = 1'b1;
    #1;
    checks++; if (ctrl0 !== 16'h1408) begin errors++; $display("[TB] FAIL ss_t1_ctrl got %h want 1408", ctrl0); end
    clockEdge();
    stepReq = 1'b0; clockEdge();
    stepReq = 1'b1; clockEdge();
    stepReq = 1'b0; clr = 1'b1;
    #1;
    checks++; if (step0 !== 3'd3) begin errors++; $display("[TB] FAIL ss_t3_step got %0d want 3", step0); end
    clockEdge(); clr = 1'b0;
    #1;
    checks++; if (step0 !== 3'd0) begin errors++; $display("[TB] FAIL ss_clr_step got %0d want 0", step0); end
    checks++; if (ctrl0 !== 16'h0000) begin errors++; $display("[TB] FAIL ss_clr_ctrl got %h want 0000", ctrl0); end
    singleStep = 1'b0;
    clockEdge();
  endtask

  task automatic test_early_end();
    logic [15:0] expCtrl[4] = '{16'h4004, 16'h1408, 16'h0A00, 16'h4004};
    int          expStep[4] = '{0, 1, 2, 0};
    clr = 1'b1; clockEdge(); clr = 1'b0;
    instr = 8'h55;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctrl1 !== expCtrl[i]) begin errors++; $display("[TB] FAIL early_ctrl[%0d] got %h want %h", i, ctrl1, expCtrl[i]); end
      checks++; if (int'(step1) != expStep[i]) begin errors++; $display("[TB] FAIL early_step[%0d] got %0d want %0d", i, step1, expStep[i]); end
      clockEdge();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clr     = ($urandom_range(0, 39) == 0);
      instr   = 8'($urandom);
      ovf     = 1'($urandom_range(0, 1));
      zf      = 1'($urandom_range(0, 1));
      stepReq = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) singleStep = ~singleStep;
      #1;
      checks++; if (ctrl0 !== refCtrl(0)) begin errors++; $display("[TB] FAIL rnd_ctrl[%0d] got %h want %h", i, ctrl0, refCtrl(0)); end
      checks++; if (int'(step0) != mStep[0]) begin errors++; $display("[TB] FAIL rnd_step[%0d] got %0d want %0d", i, step0, mStep[0]); end
      checks++; if (halted0 !== mHalted[0]) begin errors++; $display("[TB] FAIL rnd_halted[%0d] got %b want %b", i, halted0, mHalted[0]); end
      checks++; if (fetch0 !== (mStep[0] < 2)) begin errors++; $display("[TB] FAIL rnd_fetch[%0d] got %b", i, fetch0); end
      checks++; if (ctrl1 !== refCtrl(1)) begin errors++; $display("[TB] FAIL rnd_ctrl_early[%0d] got %h want %h", i, ctrl1, refCtrl(1)); end
      checks++; if (int'(step1) != mStep[1]) begin errors++; $display("[TB] FAIL rnd_step_early[%0d] got %0d want %0d", i, step1, mStep[1]); end
      checks++; if (halted1 !== mHalted[1]) begin errors++; $display("[TB] FAIL rnd_halted_early[%0d] got %b want %b", i, halted1, mHalted[1]); end
      clockEdge();
    end
  endtask

  initial begin
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) opTable[o][s] = 16'h0000;
    opTable[1] = '{16'h4800, 16'h1200, 16'h0000};
    opTable[2] = '{16'h4800, 16'h1020, 16'h0281};
    opTable[3] = '{16'h4800, 16'h1020, 16'h02C1};
    opTable[4] = '{16'h4800, 16'h2100, 16'h0000};
    opTable[5] = '{16'h0A00, 16'h0000, 16'h0000};
    opTable[6] = '{16'h0802, 16'h0000, 16'h0000};
    opTable[14] = '{16'h0110, 16'h0000, 16'h0000};
    opTable[15] = '{16'h8000, 16'h0000, 16'h0000};
    mStep = '{0, 0}; mHalted = '{1'b0, 1'b0}; mReqPrev = 1'b0;
    clr = 1'b1; instr = 8'h00; ovf = 1'b0; zf = 1'b0; singleStep = 1'b0; stepReq = 1'b0;
    @(negedge clk);
    test_reset();
    test_lda_sequence();
    test_alu_jumps();
    test_halt();
    test_single_step();
    test_early_end();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
